wb_port_arbiter: RTL
====================

// Module: wb_port_arbiter
// PURPOSE
// - Shares the single register-file write port between the pipeline writeback stream (MEM/WB
//   outputs, already MemtoReg-muxed) and results from a long-latency unit (mul/div).
// - LU results are queued in a small FIFO and drained in idle WB slots.
// - A starvation counter forces a drain by stalling the pipeline.
// - Reports pending-destination hazards to decode.
// PARAMETERS
// - DATA_W        32  register data width
// - ADDR_W         5  register index width
// - BUF_DEPTH      2  LU result FIFO entries (power of two, >=2)
// - STARVE_LIMIT   4  consecutive pipeline wins with FIFO non-empty before forced drain (>=1)
// PORTS
// - clk_i        in   1       single clock, all state on rising edge
// - rst_n_i      in   1       reset, asynchronous assert, active-low
// - pipe_we_i    in   1       WB-stage RegWrite
// - pipe_rd_i    in   ADDR_W  WB-stage destination
// - pipe_data_i  in   DATA_W  WB-stage write data
// - lu_valid_i   in   1       LU result valid
// - lu_rd_i      in   ADDR_W  LU destination
// - lu_data_i    in   DATA_W  LU result
// - lu_ready_o   out  1       arbiter accepts LU result this cycle
// - chk_rs1_i    in   ADDR_W  decode source 1, for hazard check
// - chk_rs2_i    in   ADDR_W  decode source 2, for hazard check
// - chk_rd_i     in   ADDR_W  decode destination, for WAW check
// - hazard_o     out  1       decode must stall
// - stall_o      out  1       freeze pipeline: forced drain in progress
// - rf_we_o      out  1       register-file write enable
// - rf_rd_o      out  ADDR_W  register-file write address
// - rf_data_o    out  DATA_W  register-file write data
// BEHAVIOUR
// - State: FIFO {rd,data} x BUF_DEPTH, rd/wr pointers, count, starve_cnt.
//   All outputs are combinational from state and inputs; no output register.
// - Reset (rst_n_i low, async): count=0, pointers=0, starve_cnt=0, FIFO contents dropped.
//   While rst_n_i low: rf_we_o=0, stall_o=0, hazard_o=0, lu_ready_o=0.
//   Mid-operation reset loses queued results; upstream is reset too.
// - lu_ready_o = !full (from state only). A push occurs on lu_valid_i && lu_ready_o.
//   A result with lu_rd_i==0 is accepted and discarded (no push).
// - force = (starve_cnt==STARVE_LIMIT) && !empty; stall_o = force.
// - Grant priority each cycle:
//   1. force -> FIFO head (pop); pipe_we_i ignored, because the stalled pipeline re-presents it.
//   2. pipe_we_i && pipe_rd_i!=0 -> pipeline.
//   3. !empty -> FIFO head (pop).
//   4. Otherwise no write (rf_we_o=0).
//   Pipeline writes to x0 never assert rf_we_o.
// - starve_cnt rules:
//   - 0 when empty or on any pop.
//   - +1 when pipeline is granted with FIFO non-empty.
//   - Saturates at STARVE_LIMIT.
// - Simultaneous push and pop: count unchanged, pointers both advance, wrap modulo BUF_DEPTH.
//   Push while full cannot occur (ready low).
// - A pushed entry is writable no earlier than the next cycle (min latency 1), except via bypass.
// - hazard_o: any nonzero chk_rs1_i/chk_rs2_i/chk_rd_i equals the rd of a valid FIFO entry.
//   The check also covers the LU result being accepted this cycle.
//   The arbiter never reorders writes; ordering relies on decode honouring hazard_o.
// CONFIGURATION
// - WB_BYPASS_EN defined: if FIFO empty, !force, and no pipeline write this cycle, an accepted
//   LU result is written straight through the same cycle (grant BYP, no push, starve_cnt unchanged).
// - WB_BYPASS_EN undefined: every LU result goes through the FIFO (latency >=1).
// STRUCTURE
// - Package wb_arb_pkg holds:
//   - DATA_W/ADDR_W defaults;
//   - typedef wb_entry_t {rd, data};
//   - enum grant_t {GNT_NONE, GNT_PIPE, GNT_BUF, GNT_BYP}.
// - Sub-module wb_result_fifo (BUF_DEPTH-entry circular buffer with push/pop/full/empty and
//   per-entry rd/valid taps for hazard compare).
// - Grant, starve counter and hazard compare live in the top.
// TESTING
// - Reset then idle:
//   rst_n_i low 3 cycles, release -> lu_ready_o=1, rf_we_o=0, stall_o=0, hazard_o=0.
// - Idle-slot drain:
//   LU pushes {rd=5, data=0x1234} with pipe_we_i=0 -> next cycle rf_we_o=1, rf_rd_o=5,
//   rf_data_o=0x1234, FIFO empty.
// - Pipeline priority plus forced drain:
//   FIFO holds rd=7 with pipe_we_i=1 every cycle -> 4 pipe writes, then stall_o=1 and rd=7 written.
//   The following cycle stall_o=0 and the held pipe write completes.
// - Full and wrap-around:
//   3 back-to-back LU results under a busy pipe -> lu_ready_o=0 after 2.
//   Third is accepted after a pop; results are written in order across the pointer wrap.
// - Hazard and x0:
//   FIFO holds rd=9, chk_rs2_i=9 -> hazard_o=1; chk_rs1_i=0 -> 0.
//   LU rd=0 is accepted and never written.
// - Bypass:
//   with WB_BYPASS_EN, empty FIFO, pipe idle, LU {rd=3, 0xBEEF} -> same-cycle write.
//   Without it, the write lands 1 cycle later.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and default widths for the writeback port arbiter.
// Optional feature macro used by the top: WB_BYPASS_EN (same-cycle LU write-through).
package wb_arb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // One queued long-latency result at the default widths.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Who owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_BUF  = 2'd2,
    GNT_BYP  = 2'd3
  } grant_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer for long-latency results. Exposes per-entry rd/valid taps
// so the top can compare decode sources against every pending destination.
module wb_result_fifo #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_rd_i,
  input  logic [DATA_W-1:0]            push_data_i,
  input  logic                         pop_i,
  output logic [ADDR_W-1:0]            head_rd_o,
  output logic [DATA_W-1:0]            head_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] ent_rd_o,
  output logic [DEPTH-1:0]             ent_vld_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    vld_d      = vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push_i) begin
      mem_rd_d[wr_ptr_q]   = push_rd_i;
      mem_data_d[wr_ptr_q] = push_data_i;
      vld_d[wr_ptr_q]      = 1'b1;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (push_i && !pop_i) count_d = count_q + CNT_W'(1);
    else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
  end

  // State registers; a reset drops every queued entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_rd_q   <= '0;
      mem_data_q <= '0;
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      vld_q      <= vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head_rd_o   = mem_rd_q[rd_ptr_q];
  assign head_data_o = mem_data_q[rd_ptr_q];
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign ent_rd_o    = mem_rd_q;
  assign ent_vld_o   = vld_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline WB stream and queued
// long-latency results, with starvation-forced drains and decode hazard reporting.
// Optional: define WB_BYPASS_EN to write an LU result straight through when the port is idle.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W       = wb_arb_pkg::DATA_W,
  parameter int ADDR_W       = wb_arb_pkg::ADDR_W,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              pipe_we_i,
  input  logic [ADDR_W-1:0] pipe_rd_i,
  input  logic [DATA_W-1:0] pipe_data_i,
  input  logic              lu_valid_i,
  input  logic [ADDR_W-1:0] lu_rd_i,
  input  logic [DATA_W-1:0] lu_data_i,
  output logic              lu_ready_o,
  input  logic [ADDR_W-1:0] chk_rs1_i,
  input  logic [ADDR_W-1:0] chk_rs2_i,
  input  logic [ADDR_W-1:0] chk_rd_i,
  output logic              hazard_o,
  output logic              stall_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_rd_o,
  output logic [DATA_W-1:0] rf_data_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]                    starve_q, starve_d;
  logic                             full, empty, push, pop;
  logic [ADDR_W-1:0]                head_rd;
  logic [DATA_W-1:0]                head_data;
  logic [BUF_DEPTH-1:0][ADDR_W-1:0] ent_rd;
  logic [BUF_DEPTH-1:0]             ent_vld;
  logic                             accept, lu_keep, pipe_wr, force_drain, hit;
  grant_t                           grant;

  wb_result_fifo #(
    .DEPTH (BUF_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .push_i     (push),
    .push_rd_i  (lu_rd_i),
    .push_data_i(lu_data_i),
    .pop_i      (pop),
    .head_rd_o  (head_rd),
    .head_data_o(head_data),
    .full_o     (full),
    .empty_o    (empty),
    .ent_rd_o   (ent_rd),
    .ent_vld_o  (ent_vld)
  );

  // Port grant, FIFO push/pop and starvation counter next-state.
  always_comb begin
    accept      = rst_n_i && lu_valid_i && !full;
    lu_keep     = accept && (lu_rd_i != '0);
    pipe_wr     = pipe_we_i && (pipe_rd_i != '0);
    force_drain = (starve_q == SW'(STARVE_LIMIT)) && !empty;
    grant       = GNT_NONE;
    if (force_drain)  grant = GNT_BUF;
    else if (pipe_wr) grant = GNT_PIPE;
    else if (!empty)  grant = GNT_BUF;
`ifdef WB_BYPASS_EN
    else if (lu_keep) grant = GNT_BYP;
`endif
    pop  = (grant == GNT_BUF);
    push = lu_keep && (grant != GNT_BYP);

    starve_d = starve_q;
    if (empty || pop) starve_d = '0;
    else if (grant == GNT_PIPE && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
  end

  // Hazard compare against every pending destination and the result entering this cycle.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (ent_vld[i] && ((chk_rs1_i != '0 && chk_rs1_i == ent_rd[i]) ||
                         (chk_rs2_i != '0 && chk_rs2_i == ent_rd[i]) ||
                         (chk_rd_i  != '0 && chk_rd_i  == ent_rd[i])))
        hit = 1'b1;
    end
    if (lu_keep && ((chk_rs1_i != '0 && chk_rs1_i == lu_rd_i) ||
                    (chk_rs2_i != '0 && chk_rs2_i == lu_rd_i) ||
                    (chk_rd_i  != '0 && chk_rd_i  == lu_rd_i)))
      hit = 1'b1;
  end

  // Write-port data mux driven by the grant.
  always_comb begin
    rf_rd_o   = '0;
    rf_data_o = '0;
    case (grant)
      GNT_PIPE: begin rf_rd_o = pipe_rd_i; rf_data_o = pipe_data_i; end
      GNT_BUF:  begin rf_rd_o = head_rd;   rf_data_o = head_data;   end
      GNT_BYP:  begin rf_rd_o = lu_rd_i;   rf_data_o = lu_data_i;   end
      default:  begin rf_rd_o = '0;        rf_data_o = '0;          end
    endcase
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) starve_q <= '0;
    else          starve_q <= starve_d;
  end

  // Control outputs are held low while reset is asserted.
  assign lu_ready_o = rst_n_i && !full;
  assign stall_o    = rst_n_i && force_drain;
  assign rf_we_o    = rst_n_i && (grant != GNT_NONE);
  assign hazard_o   = rst_n_i && hit;

endmodule
